// File: rtl/knn_pkg.sv
// Shared types and constants for the KNN query sequencer.
package knn_pkg;

  localparam int unsigned KNN_PT_W     = 32;
  localparam int unsigned KNN_COORD_W  = 16;
  localparam int unsigned KNN_ADDR_W   = 7;
  localparam int unsigned KNN_NPTS_MAX = 128;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GAP   = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_ACK   = 3'd5,
    ST_RESP  = 3'd6
  } knn_state_e;

  typedef struct packed {
    logic [KNN_COORD_W-1:0] x;
    logic [KNN_COORD_W-1:0] y;
  } knn_pt_t;

endpackage

// File: rtl/knn_seq_ctrl_if.sv
// Host, sample RAM and knn_core signals seen by the sequencer.
interface knn_seq_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7
);
  logic [ADDR_W:0]   cfg_npts;
  logic              q_valid;
  logic              q_ready;
  logic [DATA_W-1:0] q_point;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              knn_start;
  logic [DATA_W-1:0] knn_data_pt;
  logic [DATA_W-1:0] knn_test_pt;
  logic              knn_valid;
  logic              knn_sample_add;
  logic [31:0]       knn_add;
  logic              knn_valid_out;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_add;
  logic              res_err;
  logic              busy;

  modport master (
    input  cfg_npts, q_valid, q_point, mem_rdata, knn_add, knn_valid_out, res_ready,
    output q_ready, mem_rd, mem_addr, knn_start, knn_data_pt, knn_test_pt, knn_valid,
           knn_sample_add, res_valid, res_add, res_err, busy
  );

  modport slave (
    output cfg_npts, q_valid, q_point, mem_rdata, knn_add, knn_valid_out, res_ready,
    input  q_ready, mem_rd, mem_addr, knn_start, knn_data_pt, knn_test_pt, knn_valid,
           knn_sample_add, res_valid, res_add, res_err, busy
  );
endinterface

// File: rtl/knn_seq_loader.sv
// Streams n reference points from sample RAM as back-to-back valid beats,
// aligned to the 1-cycle RAM read latency, and flags the last beat.
module knn_seq_loader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   n,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              knn_valid,
  output logic [DATA_W-1:0] knn_data_pt,
  output logic              last_beat
);
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] issued;

  // issued counts reads already on the bus; reading stops once it equals n
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q       <= '0;
      issued    <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      knn_valid <= 1'b0;
      last_beat <= 1'b0;
    end else begin
      knn_valid <= mem_rd;
      last_beat <= mem_rd && (issued == n_q);
      if (start) begin
        n_q      <= n;
        mem_rd   <= 1'b1;
        mem_addr <= '0;
        issued   <= CNT_W'(1);
      end else if (mem_rd) begin
        if (issued == n_q) begin
          mem_rd <= 1'b0;
        end else begin
          mem_addr <= issued[ADDR_W-1:0];
          issued   <= issued + CNT_W'(1);
        end
      end
    end
  end

  // RAM data lands in the beat cycle itself; gated so the bus is 0 when idle
  assign knn_data_pt = knn_valid ? mem_rdata : '0;

endmodule

// File: rtl/knn_seq_ctrl.sv
// Query sequencer in front of knn_core: load reference set, run search, return result.
// Define KNN_CTRL_TIMEOUT_EN to abort a search after TIMEOUT_CYC cycles in WAIT.
module knn_seq_ctrl
  import knn_pkg::*;
#(
`ifdef KNN_CTRL_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYC = 1024,
`endif
  parameter int unsigned DATA_W   = KNN_PT_W,
  parameter int unsigned ADDR_W   = KNN_ADDR_W,
  parameter int unsigned NPTS_MAX = KNN_NPTS_MAX
) (
  input  logic           clk_top,
  input  logic           rst_top,
  knn_seq_ctrl_if.master bus
);
  localparam int unsigned    CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] N_MAX = CNT_W'(NPTS_MAX);

  knn_state_e       state, state_d;
  logic [CNT_W-1:0] n_clamp;
  logic             q_acc, res_acc, ld_start, ld_last, tmo;

  assign n_clamp  = (bus.cfg_npts > N_MAX) ? N_MAX : bus.cfg_npts;
  assign q_acc    = bus.q_valid & bus.q_ready;
  assign res_acc  = bus.res_valid & bus.res_ready;
  assign ld_start = q_acc & (n_clamp != '0);

  knn_seq_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_loader (
    .clk         (clk_top),
    .rst         (rst_top),
    .start       (ld_start),
    .n           (n_clamp),
    .mem_rdata   (bus.mem_rdata),
    .mem_rd      (bus.mem_rd),
    .mem_addr    (bus.mem_addr),
    .knn_valid   (bus.knn_valid),
    .knn_data_pt (bus.knn_data_pt),
    .last_beat   (ld_last)
  );

`ifdef KNN_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] wait_cnt;

  always_ff @(posedge clk_top or posedge rst_top) begin
    if (rst_top)               wait_cnt <= '0;
    else if (state == ST_WAIT) wait_cnt <= wait_cnt + TMO_W'(1);
    else                       wait_cnt <= '0;
  end

  assign tmo = (wait_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (q_acc) state_d = (n_clamp == '0) ? ST_RESP : ST_LOAD;
      ST_LOAD:  if (ld_last) state_d = ST_GAP;
      ST_GAP:   state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.knn_valid_out) state_d = ST_ACK;
        else if (tmo)          state_d = ST_RESP;
      end
      ST_ACK:   state_d = ST_RESP;
      ST_RESP:  if (res_acc) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register; control outputs registered from next state so they track it exactly
  always_ff @(posedge clk_top or posedge rst_top) begin
    if (rst_top) begin
      state              <= ST_IDLE;
      bus.q_ready        <= 1'b0;
      bus.busy           <= 1'b0;
      bus.knn_start      <= 1'b0;
      bus.knn_sample_add <= 1'b0;
      bus.res_valid      <= 1'b0;
      bus.res_add        <= '0;
      bus.res_err        <= 1'b0;
      bus.knn_test_pt    <= '0;
    end else begin
      state              <= state_d;
      bus.q_ready        <= (state_d == ST_IDLE);
      bus.busy           <= (state_d != ST_IDLE);
      bus.knn_start      <= (state_d == ST_START) || (state_d == ST_WAIT);
      bus.knn_sample_add <= (state_d == ST_ACK);
      bus.res_valid      <= (state_d == ST_RESP);
      if (q_acc) begin
        bus.knn_test_pt <= bus.q_point;
        bus.res_add     <= '0;
        bus.res_err     <= (n_clamp == '0);
      end else if (state == ST_WAIT && bus.knn_valid_out) begin
        bus.res_add <= bus.knn_add;
      end else if (state == ST_WAIT && tmo) begin
        bus.res_add <= '0;
        bus.res_err <= 1'b1;
      end else if (res_acc) begin
        bus.res_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_knn_seq_ctrl.sv
// Self-checking bench for knn_seq_ctrl: RAM and knn_core models, vector table, scoreboard.
module tb_knn_seq_ctrl;
  import knn_pkg::*;

  localparam int unsigned ADDR_W = KNN_ADDR_W;
  localparam int unsigned N_RAM  = 1 << ADDR_W;
  localparam int          N_VEC  = 6;

  logic clk_tb = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_tb = ~clk_tb;

  knn_seq_ctrl_if #(.DATA_W(KNN_PT_W), .ADDR_W(ADDR_W)) bus ();

  knn_seq_ctrl #(
`ifdef KNN_CTRL_TIMEOUT_EN
    .TIMEOUT_CYC (16),
`endif
    .DATA_W      (KNN_PT_W),
    .ADDR_W      (ADDR_W),
    .NPTS_MAX    (KNN_NPTS_MAX)
  ) dut (
    .clk_top (clk_tb),
    .rst_top (rst),
    .bus     (bus)
  );

  logic [31:0] ram [N_RAM];

  // Sample RAM, 1-cycle read latency
  always @(posedge clk_tb) if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];

  // knn_core model: answers core_lat cycles after knn_start rises, once per start
  logic        core_en  = 1'b1;
  int          core_lat = 0;
  logic [31:0] core_add = '0;
  logic        spur_vo  = 1'b0;
  int          core_cnt = 0;
  logic        core_done = 1'b0;

  always @(posedge clk_tb or posedge rst) begin
    if (rst) begin
      bus.knn_valid_out <= 1'b0;
      bus.knn_add       <= '0;
      core_cnt          <= 0;
      core_done         <= 1'b0;
    end else begin
      bus.knn_valid_out <= spur_vo;
      if (spur_vo) bus.knn_add <= 32'hDEAD_BEEF;
      if (!bus.knn_start) begin
        core_cnt  <= 0;
        core_done <= 1'b0;
      end else if (core_en && !core_done) begin
        if (core_cnt == core_lat) begin
          bus.knn_valid_out <= 1'b1;
          bus.knn_add       <= core_add;
          core_done         <= 1'b1;
        end else begin
          core_cnt <= core_cnt + 1;
        end
      end
    end
  end

  // Bus monitor: cumulative counters, tests look at differences
  int cyc = 0, rd_cnt = 0, rd_idx = 0, addr_bad = 0, last_addr = 0;
  int beats = 0, beat_idx = 0, data_bad = 0, runs = 0, last_beat_cyc = 0;
  int start_cyc = 0, start_rise_cyc = 0, sa_cnt = 0, overlap = 0;
  logic valid_prev = 1'b0, start_prev = 1'b0;

  always @(posedge clk_tb) begin
    cyc <= cyc + 1;
    if (bus.mem_rd) begin
      rd_cnt <= rd_cnt + 1;
      if (int'(bus.mem_addr) != rd_idx) addr_bad <= addr_bad + 1;
      rd_idx    <= rd_idx + 1;
      last_addr <= int'(bus.mem_addr);
    end else begin
      rd_idx <= 0;
    end
    if (bus.knn_valid) begin
      beats <= beats + 1;
      if (bus.knn_data_pt !== ram[beat_idx]) data_bad <= data_bad + 1;
      beat_idx      <= beat_idx + 1;
      last_beat_cyc <= cyc;
      if (!valid_prev) runs <= runs + 1;
    end else begin
      beat_idx <= 0;
    end
    valid_prev <= bus.knn_valid;
    if (bus.knn_start) start_cyc <= start_cyc + 1;
    if (bus.knn_start && !start_prev) start_rise_cyc <= cyc;
    start_prev <= bus.knn_start;
    if (bus.knn_sample_add) sa_cnt <= sa_cnt + 1;
    if (bus.knn_start && bus.knn_sample_add) overlap <= overlap + 1;
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: got no response, want one within the cycle budget", name);
  endtask

  typedef struct packed {
    logic [31:0] add;
    logic        err;
  } res_t;
  res_t sb[$];

  task automatic drive_query(input logic [ADDR_W:0] npts, input logic [31:0] pt, output bit ok);
    int budget;
    budget = 0;
    @(negedge clk_tb);
    bus.cfg_npts = npts;
    bus.q_point  = pt;
    bus.q_valid  = 1'b1;
    while (!bus.q_ready && budget < 300) begin
      @(negedge clk_tb);
      budget++;
    end
    ok = bus.q_ready;
    @(negedge clk_tb);
    bus.q_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, output bit ok);
    int budget;
    budget = 0;
    while (!bus.res_valid && budget < 2000) begin
      @(negedge clk_tb);
      budget++;
    end
    ok = bus.res_valid;
    if (!ok) timeout_fail(name);
  endtask

  task automatic take_result(input string name);
    res_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: got a result, want none (scoreboard empty)", name);
    end else begin
      e = sb.pop_front();
      check({name, "_add"}, 64'(bus.res_add), 64'(e.add));
      check({name, "_err"}, 64'(bus.res_err), 64'(e.err));
    end
    bus.res_ready = 1'b1;
    @(negedge clk_tb);
    bus.res_ready = 1'b0;
  endtask

  typedef struct {
    logic [ADDR_W:0] npts;
    logic [31:0]     pt;
    logic [31:0]     core_add;
    int              lat;
    int              exp_beats;
    logic            exp_err;
    logic [31:0]     exp_add;
  } vec_t;
  vec_t vecs [N_VEC];

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test, want $finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int bad, budget;
    int b_beats, b_rd, b_db, b_ab, b_runs, b_st, b_sa;

    for (int i = 0; i < int'(N_RAM); i++)
      ram[i] = knn_pt_t'{x: 16'(20 + 10 * i), y: 16'(20 + 10 * i)};
    bus.cfg_npts  = '0;
    bus.q_valid   = 1'b0;
    bus.q_point   = '0;
    bus.res_ready = 1'b0;

    vecs[0] = '{8'd127, 32'h001E_001F, 32'd1,         2, 127, 1'b0, 32'd1};
    vecs[1] = '{8'd0,   32'h0003_0004, 32'h1111_1111, 0, 0,   1'b1, 32'd0};
    vecs[2] = '{8'd200, 32'h0010_0020, 32'h0000_0055, 3, 128, 1'b0, 32'h0000_0055};
    vecs[3] = '{8'd1,   32'h00FF_0001, 32'hABCD_0001, 0, 1,   1'b0, 32'hABCD_0001};
    vecs[4] = '{8'd128, 32'h0100_0200, 32'd7,         5, 128, 1'b0, 32'd7};
    vecs[5] = '{8'd5,   32'h0000_0000, 32'd3,         1, 5,   1'b0, 32'd3};

    repeat (3) @(negedge clk_tb);
    check("rst_outs", 64'({bus.q_ready, bus.mem_rd, bus.knn_valid, bus.knn_start,
                           bus.knn_sample_add, bus.res_valid, bus.res_err, bus.busy}), 64'(0));
    rst = 1'b0;
    @(negedge clk_tb);
    check("idle_q_ready", 64'(bus.q_ready), 64'(1));

    // Stray knn_valid_out while idle must not produce anything
    spur_vo = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk_tb);
      if (bus.res_valid || bus.busy || bus.knn_sample_add) bad++;
    end
    spur_vo = 1'b0;
    repeat (2) @(negedge clk_tb);
    check("spur_ignored", 64'(bad), 64'(0));

    for (int k = 0; k < N_VEC; k++) begin
      b_beats = beats; b_rd = rd_cnt; b_db = data_bad; b_ab = addr_bad;
      b_runs = runs; b_st = start_cyc; b_sa = sa_cnt;
      core_add = vecs[k].core_add;
      core_lat = vecs[k].lat;
      sb.push_back(res_t'{add: vecs[k].exp_add, err: vecs[k].exp_err});
      drive_query(vecs[k].npts, vecs[k].pt, ok);
      if (!ok) timeout_fail($sformatf("v%0d_accept", k));
      wait_result($sformatf("v%0d_res", k), ok);
      if (ok) take_result($sformatf("v%0d", k));
      check($sformatf("v%0d_beats", k), 64'(beats - b_beats), 64'(vecs[k].exp_beats));
      check($sformatf("v%0d_reads", k), 64'(rd_cnt - b_rd), 64'(vecs[k].exp_beats));
      check($sformatf("v%0d_data", k), 64'(data_bad - b_db), 64'(0));
      check($sformatf("v%0d_addr_seq", k), 64'(addr_bad - b_ab), 64'(0));
      check($sformatf("v%0d_runs", k), 64'(runs - b_runs), 64'(vecs[k].exp_beats > 0 ? 1 : 0));
      check($sformatf("v%0d_sample_add", k), 64'(sa_cnt - b_sa), 64'(vecs[k].exp_err ? 0 : 1));
      check($sformatf("v%0d_started", k), 64'(start_cyc != b_st), 64'(!vecs[k].exp_err));
      check($sformatf("v%0d_test_pt", k), 64'(bus.knn_test_pt), 64'(vecs[k].pt));
      if (vecs[k].exp_beats > 0) begin
        check($sformatf("v%0d_gap", k), 64'(start_rise_cyc - last_beat_cyc), 64'(2));
        check($sformatf("v%0d_last_addr", k), 64'(last_addr), 64'(vecs[k].exp_beats - 1));
      end
    end

    // Reset in the middle of LOAD
    core_add = 32'd1; core_lat = 0;
    b_beats = beats;
    drive_query(8'd127, 32'h001E_001F, ok);
    if (!ok) timeout_fail("rstmid_accept");
    budget = 0;
    while (beats - b_beats < 40 && budget < 500) begin
      @(negedge clk_tb);
      budget++;
    end
    if (beats - b_beats < 40) timeout_fail("rstmid_beats");
    rst = 1'b1;
    #1;
    check("rstmid_ctl", 64'({bus.mem_rd, bus.mem_addr, bus.knn_valid, bus.knn_start, bus.knn_sample_add,
                             bus.res_valid, bus.res_err, bus.busy, bus.q_ready}), 64'(0));
    check("rstmid_data", {bus.knn_data_pt, bus.knn_test_pt}, 64'(0));
    @(negedge clk_tb);
    rst = 1'b0;
    repeat (2) @(negedge clk_tb);
    check("rstmid_q_ready", 64'(bus.q_ready), 64'(1));
    bad = 0;
    repeat (20) begin
      @(negedge clk_tb);
      if (bus.res_valid || bus.busy) bad++;
    end
    check("rstmid_no_result", 64'(bad), 64'(0));

    // Result backpressure with a pending query
    core_add = 32'h0000_0042; core_lat = 1;
    sb.push_back(res_t'{add: 32'h0000_0042, err: 1'b0});
    drive_query(8'd3, 32'h0001_0002, ok);
    if (!ok) timeout_fail("bp_accept");
    wait_result("bp_res", ok);
    core_add = 32'h0000_0077;
    sb.push_back(res_t'{add: 32'h0000_0077, err: 1'b0});
    bus.cfg_npts = 8'd4;
    bus.q_point  = 32'h0005_0006;
    bus.q_valid  = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk_tb);
      if (!bus.res_valid || bus.res_add !== 32'h0000_0042 || bus.res_err !== 1'b0 || bus.q_ready) bad++;
    end
    check("bp_hold", 64'(bad), 64'(0));
    take_result("bp1");
    check("bp_idle", 64'({bus.q_ready, bus.busy, bus.res_valid}), 64'(3'b100));
    @(negedge clk_tb);
    check("bp_accept_next", 64'({bus.busy, bus.mem_rd, bus.q_ready}), 64'(3'b110));
    bus.q_valid = 1'b0;
    wait_result("bp2_res", ok);
    if (ok) take_result("bp2");

`ifdef KNN_CTRL_TIMEOUT_EN
    // Core never answers: abort after 16 WAIT cycles
    core_en = 1'b0;
    b_st = start_cyc; b_sa = sa_cnt;
    sb.push_back(res_t'{add: 32'd0, err: 1'b1});
    drive_query(8'd2, 32'h0009_0009, ok);
    if (!ok) timeout_fail("tmo_accept");
    wait_result("tmo_res", ok);
    if (ok) take_result("tmo");
    check("tmo_start_cycles", 64'(start_cyc - b_st), 64'(17));
    check("tmo_no_ack", 64'(sa_cnt - b_sa), 64'(0));
    core_en = 1'b1;
`endif

    check("start_ack_overlap", 64'(overlap), 64'(0));
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
